store_drain_buffer: RTL and testbench

- In-order FIFO of committed stores, sitting directly upstream of the data cache store request port.
- Accepts stores from the commit stage with a valid/ready handshake.
- Drains stores one at a time using the dcache two-phase protocol: index phase with req/gnt, then a tag phase.
- Reports empty status for fence/flush, and optionally flags store-to-load address conflicts.

---
 rtl/store_drain_buffer.sv | 194 +++++++++++++++++++
 tb/tb_store_drain_buffer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_buffer.sv
// In-order committed-store FIFO that drains into the dcache with a two-phase (index req/gnt, then tag) protocol.
// Optional store-to-load index match port enabled by defining STORE_DRAIN_BUFFER_FWD_EN.
module store_drain_buffer #(
  parameter int DEPTH   = 8,
  parameter int INDEX_W = 12,
  parameter int TAG_W   = 44,
  parameter int DATA_W  = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_valid_i,
  output logic                           push_ready_o,
  input  logic [TAG_W+INDEX_W-1:0]       push_addr_i,
  input  logic [DATA_W-1:0]              push_data_i,
  input  logic [DATA_W/8-1:0]            push_be_i,
  input  logic [1:0]                     push_size_i,
  input  logic                           flush_i,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     usage_o,
  output logic                           dcache_req_o,
  input  logic                           dcache_gnt_i,
  output logic [INDEX_W-1:0]             dcache_index_o,
  output logic [TAG_W-1:0]               dcache_tag_o,
  output logic                           dcache_tag_valid_o,
  output logic                           dcache_we_o,
  output logic [DATA_W-1:0]              dcache_wdata_o,
  output logic [DATA_W/8-1:0]            dcache_be_o,
  output logic [1:0]                     dcache_size_o,
`ifdef STORE_DRAIN_BUFFER_FWD_EN
  input  logic [INDEX_W-1:0]             chk_index_i,
  output logic                           chk_match_o,
`endif
  output logic                           dcache_kill_o
);

  localparam int ADDR_W = TAG_W + INDEX_W;
  localparam int BE_W   = DATA_W / 8;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_TAG} state_t;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [BE_W-1:0]   be_mem   [DEPTH];
  logic [1:0]        size_mem [DEPTH];

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              req_q, req_d;
  logic              tag_valid_q, tag_valid_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [1:0]        size_q, size_d;

  logic              push_fire;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [BE_W-1:0]   head_be;
  logic [1:0]        head_size;

  assign push_ready_o = (count_q < DEPTH_CNT) && !flush_i;
  assign push_fire    = push_valid_i && push_ready_o;
  assign pop          = (state_q == S_TAG);

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push_fire) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_fire, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_REQ;
      S_REQ:   if (dcache_gnt_i) state_d = S_TAG;
      S_TAG:   state_d = (count_d != '0) ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The next head may be the entry being written this very edge (push during the pop of the last entry).
  always_comb begin
    head_addr = addr_mem[rd_ptr_d];
    head_data = data_mem[rd_ptr_d];
    head_be   = be_mem[rd_ptr_d];
    head_size = size_mem[rd_ptr_d];
    if (push_fire && (wr_ptr_q == rd_ptr_d)) begin
      head_addr = push_addr_i;
      head_data = push_data_i;
      head_be   = push_be_i;
      head_size = push_size_i;
    end
  end

  always_comb begin
    req_d       = (state_d == S_REQ);
    tag_valid_d = (state_d == S_TAG);
    index_d     = '0;
    wdata_d     = '0;
    be_d        = '0;
    size_d      = '0;
    tag_d       = '0;
    if (state_d == S_REQ) begin
      index_d = head_addr[INDEX_W-1:0];
      wdata_d = head_data;
      be_d    = head_be;
      size_d  = head_size;
    end
    if (state_d == S_TAG) begin
      tag_d = head_addr[ADDR_W-1:INDEX_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      addr_mem[wr_ptr_q] <= push_addr_i;
      data_mem[wr_ptr_q] <= push_data_i;
      be_mem[wr_ptr_q]   <= push_be_i;
      size_mem[wr_ptr_q] <= push_size_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      req_q       <= 1'b0;
      tag_valid_q <= 1'b0;
      index_q     <= '0;
      tag_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      size_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      req_q       <= req_d;
      tag_valid_q <= tag_valid_d;
      index_q     <= index_d;
      tag_q       <= tag_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      size_q      <= size_d;
    end
  end

  assign usage_o            = count_q;
  assign empty_o            = (count_q == '0) && (state_q == S_IDLE);
  assign dcache_req_o       = req_q;
  assign dcache_we_o        = req_q;
  assign dcache_tag_valid_o = tag_valid_q;
  assign dcache_index_o     = index_q;
  assign dcache_tag_o       = tag_q;
  assign dcache_wdata_o     = wdata_q;
  assign dcache_be_o        = be_q;
  assign dcache_size_o      = size_q;
  assign dcache_kill_o      = 1'b0;

`ifdef STORE_DRAIN_BUFFER_FWD_EN
  // Match on the 8-byte word: entry is live when its distance from the head is below the count.
  logic [DEPTH-1:0] hit;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_chk
    logic [PTR_W-1:0] offs;
    assign offs    = PTR_W'(gi) - rd_ptr_q;
    assign hit[gi] = (CNT_W'(offs) < count_q) &&
                     (addr_mem[gi][INDEX_W-1:3] == chk_index_i[INDEX_W-1:3]);
  end
  assign chk_match_o = |hit;
`endif

endmodule

// File: tb/tb_store_drain_buffer.sv
// Randomized scoreboard bench for store_drain_buffer: accepted stores are queued in push order and
// compared against what the dcache port presents, plus directed boundary scenarios.
module tb_store_drain_buffer;

  localparam int DEPTH   = 8;
  localparam int INDEX_W = 12;
  localparam int TAG_W   = 44;
  localparam int DATA_W  = 64;
  localparam int ADDR_W  = TAG_W + INDEX_W;
  localparam int BE_W    = DATA_W / 8;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
    logic [1:0]        size;
  } store_t;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               push_valid_i;
  logic               push_ready_o;
  logic [ADDR_W-1:0]  push_addr_i;
  logic [DATA_W-1:0]  push_data_i;
  logic [BE_W-1:0]    push_be_i;
  logic [1:0]         push_size_i;
  logic               flush_i;
  logic               empty_o;
  logic [CNT_W-1:0]   usage_o;
  logic               dcache_req_o;
  logic               dcache_gnt_i;
  logic [INDEX_W-1:0] dcache_index_o;
  logic [TAG_W-1:0]   dcache_tag_o;
  logic               dcache_tag_valid_o;
  logic               dcache_we_o;
  logic [DATA_W-1:0]  dcache_wdata_o;
  logic [BE_W-1:0]    dcache_be_o;
  logic [1:0]         dcache_size_o;
  logic               dcache_kill_o;
`ifdef STORE_DRAIN_BUFFER_FWD_EN
  logic [INDEX_W-1:0] chk_index_i;
  logic               chk_match_o;
`endif

  int tests = 0;
  int fails = 0;
  int tag_cnt = 0;
  store_t sb[$];

  always #5 clk_i = ~clk_i;

  store_drain_buffer #(
    .DEPTH(DEPTH), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_addr_i(push_addr_i), .push_data_i(push_data_i),
    .push_be_i(push_be_i), .push_size_i(push_size_i),
    .flush_i(flush_i), .empty_o(empty_o), .usage_o(usage_o),
    .dcache_req_o(dcache_req_o), .dcache_gnt_i(dcache_gnt_i),
    .dcache_index_o(dcache_index_o), .dcache_tag_o(dcache_tag_o),
    .dcache_tag_valid_o(dcache_tag_valid_o), .dcache_we_o(dcache_we_o),
    .dcache_wdata_o(dcache_wdata_o), .dcache_be_o(dcache_be_o),
    .dcache_size_o(dcache_size_o),
`ifdef STORE_DRAIN_BUFFER_FWD_EN
    .chk_index_i(chk_index_i), .chk_match_o(chk_match_o),
`endif
    .dcache_kill_o(dcache_kill_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares status against the queue of outstanding stores and each tag phase against the oldest store.
  logic              in_req = 1'b0;
  logic              expect_tag = 1'b0;
  logic [INDEX_W-1:0] cap_index;
  logic [DATA_W-1:0] cap_data;
  logic [BE_W-1:0]   cap_be;
  logic [1:0]        cap_size;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      sb.delete();
      in_req     = 1'b0;
      expect_tag = 1'b0;
    end else begin
      store_t exp_s;
      check("usage", 64'(usage_o), 64'(sb.size()));
      check("empty", 64'(empty_o), 64'(sb.size() == 0));
      check("push_ready", 64'(push_ready_o), 64'((sb.size() < DEPTH) && !flush_i));
      check("we_eq_req", 64'(dcache_we_o), 64'(dcache_req_o));
      check("kill", 64'(dcache_kill_o), 64'd0);
      if (expect_tag) check("tag_after_gnt", 64'(dcache_tag_valid_o), 64'd1);
      if (dcache_tag_valid_o) begin
        check("tag_expected", 64'(expect_tag), 64'd1);
        check("req_low_in_tag", 64'(dcache_req_o), 64'd0);
        tag_cnt++;
        if (sb.size() == 0) begin
          check("sb_nonempty_at_tag", 64'd0, 64'd1);
        end else begin
          exp_s = sb.pop_front();
          check("tag", 64'(dcache_tag_o), 64'(exp_s.addr[ADDR_W-1:INDEX_W]));
          check("index", 64'(cap_index), 64'(exp_s.addr[INDEX_W-1:0]));
          check("wdata", cap_data, exp_s.data);
          check("be", 64'(cap_be), 64'(exp_s.be));
          check("size", 64'(cap_size), 64'(exp_s.size));
          $display("[TB] drained store tag=0x%0h idx=0x%0h data=0x%0h", dcache_tag_o, cap_index, cap_data);
        end
      end else begin
        check("tag_idle_zero", 64'(dcache_tag_o), 64'd0);
      end
      if (!dcache_req_o) begin
        check("idle_index_zero", 64'(dcache_index_o), 64'd0);
        check("idle_data_zero", dcache_wdata_o, 64'd0);
      end
      expect_tag = dcache_req_o && dcache_gnt_i;
      if (dcache_req_o) begin
        if (in_req) begin
          check("req_index_stable", 64'(dcache_index_o), 64'(cap_index));
          check("req_data_stable", dcache_wdata_o, cap_data);
          check("req_be_stable", 64'(dcache_be_o), 64'(cap_be));
          check("req_size_stable", 64'(dcache_size_o), 64'(cap_size));
        end
        cap_index = dcache_index_o;
        cap_data  = dcache_wdata_o;
        cap_be    = dcache_be_o;
        cap_size  = dcache_size_o;
      end
      in_req = dcache_req_o && !dcache_gnt_i;
      if (push_valid_i && push_ready_o) begin
        exp_s.addr = push_addr_i;
        exp_s.data = push_data_i;
        exp_s.be   = push_be_i;
        exp_s.size = push_size_i;
        sb.push_back(exp_s);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_rand_push();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    push_valid_i = 1'b1;
    push_addr_i  = r[ADDR_W-1:0];
    push_data_i  = {$urandom(), $urandom()};
    push_be_i    = BE_W'($urandom());
    push_size_i  = 2'($urandom());
  endtask

  task automatic wait_empty(input int budget, input string name);
    int n = 0;
    @(negedge clk_i);
    while (!empty_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check(name, 64'(empty_o), 64'd1);
  endtask

  initial begin
    int tag_before;
    rst_ni = 1'b0; push_valid_i = 1'b0; push_addr_i = '0; push_data_i = '0;
    push_be_i = '0; push_size_i = '0; flush_i = 1'b0; dcache_gnt_i = 1'b0;
`ifdef STORE_DRAIN_BUFFER_FWD_EN
    chk_index_i = '0;
`endif
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_usage", 64'(usage_o), 64'd0);
    check("rst_empty", 64'(empty_o), 64'd1);
    check("rst_ready", 64'(push_ready_o), 64'd1);
    check("rst_req", 64'(dcache_req_o), 64'd0);
    check("rst_tag_valid", 64'(dcache_tag_valid_o), 64'd0);
    check("rst_we", 64'(dcache_we_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    dcache_gnt_i = 1'b1;

    // Single store with immediate grant: req one cycle after push, then tag, then empty.
    push_valid_i = 1'b1; push_addr_i = 56'h0000_1234_5678; push_data_i = 64'hDEAD_BEEF;
    push_be_i = 8'h0F; push_size_i = 2'd2;
    tick();
    push_valid_i = 1'b0;
    @(negedge clk_i);
    check("t1_req_not_yet", 64'(dcache_req_o), 64'd0);
    @(negedge clk_i);
    check("t1_req", 64'(dcache_req_o), 64'd1);
    check("t1_index", 64'(dcache_index_o), 64'h678);
    check("t1_wdata", dcache_wdata_o, 64'hDEAD_BEEF);
    @(negedge clk_i);
    check("t1_tag_valid", 64'(dcache_tag_valid_o), 64'd1);
    check("t1_tag", 64'(dcache_tag_o), 64'h12345);
    @(negedge clk_i);
    check("t1_empty", 64'(empty_o), 64'd1);

    // Fill with grant withheld; ninth push must be refused.
    tick();
    dcache_gnt_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive_rand_push();
      tick();
    end
    push_valid_i = 1'b0;
    @(negedge clk_i);
    check("full_usage", 64'(usage_o), 64'd8);
    check("full_ready", 64'(push_ready_o), 64'd0);
    tick();
    dcache_gnt_i = 1'b1;
    wait_empty(60, "full_drain_empty");
    check("full_drain_usage", 64'(usage_o), 64'd0);

    // Grant withheld several cycles in REQ: exactly one tag phase follows.
    tick();
    dcache_gnt_i = 1'b0;
    tag_before = tag_cnt;
    drive_rand_push();
    tick();
    push_valid_i = 1'b0;
    repeat (6) tick();
    dcache_gnt_i = 1'b1;
    wait_empty(20, "stall_empty");
    check("stall_one_tag", 64'(tag_cnt - tag_before), 64'd1);

    // Push lands on the edge that pops the only entry: count stays 1, FSM goes straight to REQ.
    tick();
    drive_rand_push();
    tick();
    push_valid_i = 1'b0;
    tick();
    tick();
    drive_rand_push();
    @(negedge clk_i);
    check("pp_tag_phase", 64'(dcache_tag_valid_o), 64'd1);
    tick();
    push_valid_i = 1'b0;
    @(negedge clk_i);
    check("pp_usage", 64'(usage_o), 64'd1);
    check("pp_req", 64'(dcache_req_o), 64'd1);
    wait_empty(20, "pp_empty");

    // Flush with three entries buffered.
    tick();
    dcache_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand_push();
      tick();
    end
    flush_i = 1'b1;
    drive_rand_push();
    @(negedge clk_i);
    check("flush_ready", 64'(push_ready_o), 64'd0);
    check("flush_usage", 64'(usage_o), 64'd3);
    tick();
    dcache_gnt_i = 1'b1;
    wait_empty(40, "flush_empty");
    tick();
    flush_i = 1'b0;
    push_valid_i = 1'b0;

    // Reset while a request is outstanding.
    dcache_gnt_i = 1'b0;
    drive_rand_push();
    tick();
    push_valid_i = 1'b0;
    repeat (2) tick();
    @(negedge clk_i);
    check("rr_req_before", 64'(dcache_req_o), 64'd1);
    tick();
    rst_ni = 1'b0;
    tick();
    check("rr_req", 64'(dcache_req_o), 64'd0);
    check("rr_usage", 64'(usage_o), 64'd0);
    check("rr_empty", 64'(empty_o), 64'd1);
    rst_ni = 1'b1;

`ifdef STORE_DRAIN_BUFFER_FWD_EN
    push_valid_i = 1'b1; push_addr_i = 56'h0000_0000_0678; push_data_i = 64'h1;
    tick();
    push_valid_i = 1'b0;
    chk_index_i = 12'h67C;
    @(negedge clk_i);
    check("fwd_match", 64'(chk_match_o), 64'd1);
    chk_index_i = 12'h680;
    #1;
    check("fwd_nomatch", 64'(chk_match_o), 64'd0);
    tick();
    dcache_gnt_i = 1'b1;
    wait_empty(20, "fwd_empty");
`endif

    // Randomized traffic with random grant and occasional flush; exercises pointer wrap many times.
    for (int c = 0; c < 500; c++) begin
      tick();
      if (($urandom() % 10) < 6) drive_rand_push();
      else push_valid_i = 1'b0;
      dcache_gnt_i = 1'($urandom());
      flush_i = (($urandom() % 16) == 0);
    end
    tick();
    push_valid_i = 1'b0;
    flush_i = 1'b0;
    dcache_gnt_i = 1'b1;
    wait_empty(100, "final_empty");
    @(negedge clk_i);
    check("final_sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
